// File: rtl/grid_ccff_loader_if.sv
// Configuration-chain bus between a tile loader and whoever drives its chain.
// Optional readback request line is present only when CCFF_READBACK_EN is defined.
interface grid_ccff_loader_if #(
   parameter int CHAIN_LEN = 64
);
   logic                 config_enable;
   logic                 ccff_head;
   logic                 ccff_tail;
   logic [CHAIN_LEN-1:0] cfg_bits;
   logic                 cfg_done;
   logic                 cfg_err;
`ifdef CCFF_READBACK_EN
   logic                 cfg_rdbk;

   modport master (
      output config_enable, ccff_head, cfg_rdbk,
      input  ccff_tail, cfg_bits, cfg_done, cfg_err
   );

   modport slave (
      input  config_enable, ccff_head, cfg_rdbk,
      output ccff_tail, cfg_bits, cfg_done, cfg_err
   );
`else
   modport master (
      output config_enable, ccff_head,
      input  ccff_tail, cfg_bits, cfg_done, cfg_err
   );

   modport slave (
      input  config_enable, ccff_head,
      output ccff_tail, cfg_bits, cfg_done, cfg_err
   );
`endif
endinterface

// File: rtl/grid_ccff_loader.sv
// Serial configuration-chain loader for one fabric tile.
// Bits shift MSB-first through sr; a full-length load is committed to the
// shadow register cfg_bits when config_enable drops, a short load is rejected.
// Optional feature macro: CCFF_READBACK_EN (cfg_rdbk copies cfg_bits back into sr).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no load in progress, no valid committed config (reset/rejected)
// SHIFT | load in progress, cnt counts bits shifted (saturating)
// DONE  | last load committed, cfg_done high
module grid_ccff_loader #(
   parameter int CHAIN_LEN = 64
) (
   input  logic prog_clk,
   input  logic pReset,
   grid_ccff_loader_if.slave bus
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CHAIN_LEN-1:0] sr_q, sr_d;
   logic [CHAIN_LEN-1:0] cfg_bits_q, cfg_bits_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 cfg_done_q, cfg_done_d;
   logic                 cfg_err_q, cfg_err_d;

   logic                 shift_en;
   logic                 rdbk_req;

   assign shift_en = bus.config_enable;
`ifdef CCFF_READBACK_EN
   assign rdbk_req = bus.cfg_rdbk;
`else
   assign rdbk_req = 1'b0;
`endif

   // State register with synchronous reset.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: any enable starts a load; the first low enable ends it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (shift_en) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!shift_en) begin
               state_d = (cnt_q == CNT_FULL) ? DONE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: shift, count, commit/reject and optional readback.
   always_comb begin
      sr_d       = sr_q;
      cfg_bits_d = cfg_bits_q;
      cnt_d      = cnt_q;
      cfg_done_d = cfg_done_q;
      cfg_err_d  = cfg_err_q;

      // Shifting happens in every state; readback only when idle/done and not shifting.
      if (shift_en) begin
         sr_d = {sr_q[CHAIN_LEN-2:0], bus.ccff_head};
      end else if (rdbk_req && (state_q != SHIFT)) begin
         sr_d = cfg_bits_q;
      end

      unique case (state_q)
         IDLE, DONE: begin
            if (shift_en) begin
               cnt_d      = CNT_ONE;
               cfg_done_d = 1'b0;
               cfg_err_d  = 1'b0;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               // Saturate so surplus bits just flow through to the tail.
               if (cnt_q != CNT_FULL) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               cnt_d = '0;
               if (cnt_q == CNT_FULL) begin
                  cfg_bits_d = sr_q;
                  cfg_done_d = 1'b1;
               end else begin
                  cfg_err_d  = 1'b1;
               end
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Datapath registers with synchronous reset; a load in progress is discarded.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         sr_q       <= '0;
         cfg_bits_q <= '0;
         cnt_q      <= '0;
         cfg_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         sr_q       <= sr_d;
         cfg_bits_q <= cfg_bits_d;
         cnt_q      <= cnt_d;
         cfg_done_q <= cfg_done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // Tail comes straight from the last shift-register flop.
   assign bus.ccff_tail = sr_q[CHAIN_LEN-1];
   assign bus.cfg_bits  = cfg_bits_q;
   assign bus.cfg_done  = cfg_done_q;
   assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_grid_ccff_loader.sv
// Self-checking bench for grid_ccff_loader (CHAIN_LEN = 8).
// Reference model: a queue of the last CHAIN_LEN bits shifted plus a load-length tally.
module tb_grid_ccff_loader;

   localparam int CL = 8;
`ifdef CCFF_READBACK_EN
   localparam bit RDBK = 1'b1;
`else
   localparam bit RDBK = 1'b0;
`endif

   logic prog_clk = 1'b0;
   logic pReset   = 1'b1;

   grid_ccff_loader_if #(.CHAIN_LEN(CL)) bus ();

   grid_ccff_loader #(.CHAIN_LEN(CL)) dut (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .bus      (bus)
   );

   always #5 prog_clk = ~prog_clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Behavioural model
   bit             m_hist[$];   // m_hist[0] = oldest of the last CL shifted bits
   logic [CL-1:0]  m_cfg;
   bit             m_done;
   bit             m_err;
   bit             m_in_load;
   int             m_len;

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < CL; i++) m_hist.push_back(1'b0);
      m_cfg     = '0;
      m_done    = 1'b0;
      m_err     = 1'b0;
      m_in_load = 1'b0;
      m_len     = 0;
   endtask

   // Drive one cycle of inputs, advance the model on the edge, settle 1 time unit.
   task automatic step(input bit rst, input bit en, input bit hd, input bit rb);
      @(negedge prog_clk);
      pReset            = rst;
      bus.config_enable = en;
      bus.ccff_head     = hd;
`ifdef CCFF_READBACK_EN
      bus.cfg_rdbk      = rb;
`endif
      @(posedge prog_clk);
      if (rst) begin
         model_reset();
      end else if (en) begin
         m_hist.push_back(hd);
         void'(m_hist.pop_front());
         if (!m_in_load) begin
            m_in_load = 1'b1;
            m_len     = 1;
            m_done    = 1'b0;
            m_err     = 1'b0;
         end else begin
            m_len++;
         end
      end else if (m_in_load) begin
         m_in_load = 1'b0;
         if (m_len >= CL) begin
            for (int i = 0; i < CL; i++) m_cfg[CL-1-i] = m_hist[i];
            m_done = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end else if (rb && RDBK) begin
         for (int i = 0; i < CL; i++) m_hist[i] = m_cfg[CL-1-i];
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      tests_run++;
      if (bus.cfg_bits !== '0 || bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0 || bus.ccff_tail !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset: bits=%b done=%b err=%b tail=%b, required all 0",
                  bus.cfg_bits, bus.cfg_done, bus.cfg_err, bus.ccff_tail);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: done=%b err=%b, required 0 0", bus.cfg_done, bus.cfg_err);
      end
   endtask

   task automatic test_full_load();
      logic [CL-1:0] pat;
      pat = 8'b10110010;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = CL - 1; i >= 0; i--) begin
         step(1'b0, 1'b1, pat[i], 1'b0);
         tests_run++;
         if (bus.cfg_bits !== '0 || bus.cfg_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_load_shifting: bits=%b done=%b, required 0 0", bus.cfg_bits, bus.cfg_done);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_bits !== 8'b10110010 || bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b0 || bus.ccff_tail !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_load_commit: bits=%b done=%b err=%b tail=%b, required 10110010 1 0 1",
                  bus.cfg_bits, bus.cfg_done, bus.cfg_err, bus.ccff_tail);
      end
   endtask

   task automatic test_short_load();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_err !== 1'b1 || bus.cfg_done !== 1'b0 || bus.cfg_bits !== '0) begin
         tests_failed++;
         $display("FAIL short_load: err=%b done=%b bits=%b, required 1 0 00000000",
                  bus.cfg_err, bus.cfg_done, bus.cfg_bits);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_err !== 1'b1 || bus.cfg_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL short_load_hold: err=%b done=%b, required 1 0", bus.cfg_err, bus.cfg_done);
      end
   endtask

   task automatic test_overflow();
      bit a[12];
      logic [CL-1:0] exp_bits;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      foreach (a[i]) a[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, a[i], 1'b0);
         if (i >= 7 && i <= 10) begin
            tests_run++;
            if (bus.ccff_tail !== a[i-7]) begin
               tests_failed++;
               $display("FAIL overflow_tail[%0d]: tail=%b, required %b", i - 7, bus.ccff_tail, a[i-7]);
            end
         end
      end
      for (int j = 0; j < CL; j++) exp_bits[CL-1-j] = a[4+j];
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_bits !== exp_bits || bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow_commit: bits=%b done=%b err=%b, required %b 1 0",
                  bus.cfg_bits, bus.cfg_done, bus.cfg_err, exp_bits);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [CL-1:0] b;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < CL; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      tests_run++;
      if (bus.cfg_bits !== '0 || bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0 || bus.ccff_tail !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_load: bits=%b done=%b err=%b tail=%b, required all 0",
                  bus.cfg_bits, bus.cfg_done, bus.cfg_err, bus.ccff_tail);
      end
      b = CL'($urandom);
      for (int i = CL - 1; i >= 0; i--) step(1'b0, 1'b1, b[i], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_bits !== b || bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reload_after_reset: bits=%b done=%b err=%b, required %b 1 0",
                  bus.cfg_bits, bus.cfg_done, bus.cfg_err, b);
      end
   endtask

   task automatic test_back_to_back();
      logic [CL-1:0] pat;
      logic [CL-1:0] nb;
      pat = 8'b10110010;
      nb  = CL'($urandom);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = CL - 1; i >= 0; i--) step(1'b0, 1'b1, pat[i], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = CL - 1; i >= 0; i--) begin
         step(1'b0, 1'b1, nb[i], 1'b0);
         tests_run++;
         if (bus.cfg_done !== 1'b0 || bus.cfg_bits !== pat) begin
            tests_failed++;
            $display("FAIL back_to_back_shift: done=%b bits=%b, required 0 %b", bus.cfg_done, bus.cfg_bits, pat);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_bits !== nb || bus.cfg_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL back_to_back_commit: bits=%b done=%b, required %b 1", bus.cfg_bits, bus.cfg_done, nb);
      end
   endtask

`ifdef CCFF_READBACK_EN
   task automatic test_readback();
      logic [CL-1:0] pat;
      pat = 8'b10110010;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = CL - 1; i >= 0; i--) step(1'b0, 1'b1, pat[i], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b0 || bus.cfg_bits !== pat) begin
         tests_failed++;
         $display("FAIL readback_status: done=%b err=%b bits=%b, required 1 0 %b",
                  bus.cfg_done, bus.cfg_err, bus.cfg_bits, pat);
      end
      for (int k = 0; k < CL; k++) begin
         tests_run++;
         if (bus.ccff_tail !== pat[CL-1-k]) begin
            tests_failed++;
            $display("FAIL readback_tail[%0d]: tail=%b, required %b", k, bus.ccff_tail, pat[CL-1-k]);
         end
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.cfg_bits !== '0 || bus.cfg_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL readback_commit: bits=%b done=%b, required 00000000 1", bus.cfg_bits, bus.cfg_done);
      end
   endtask
`endif

   task automatic test_random();
      bit rst, en, hd, rb;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 11) != 0);
         hd  = 1'($urandom_range(0, 1));
         rb  = 1'($urandom_range(0, 1));
         step(rst, en, hd, rb);
         tests_run++;
         if (bus.cfg_bits !== m_cfg || bus.cfg_done !== m_done || bus.cfg_err !== m_err ||
             bus.ccff_tail !== m_hist[0]) begin
            tests_failed++;
            $display("FAIL random[%0d]: bits=%b done=%b err=%b tail=%b, required %b %b %b %b",
                     c, bus.cfg_bits, bus.cfg_done, bus.cfg_err, bus.ccff_tail,
                     m_cfg, m_done, m_err, m_hist[0]);
         end
      end
   endtask

   initial begin
      bus.config_enable = 1'b0;
      bus.ccff_head     = 1'b0;
`ifdef CCFF_READBACK_EN
      bus.cfg_rdbk      = 1'b0;
`endif
      model_reset();
      test_reset();
      test_full_load();
      test_short_load();
      test_overflow();
      test_reset_mid_load();
      test_back_to_back();
`ifdef CCFF_READBACK_EN
      test_readback();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
